// File: rtl/signal_ctrl.sv
// signal_ctrl: traffic-signal controller for N_CH vehicle approaches with a
// shared pedestrian walk phase, round-robin service and emergency preemption.
// Outputs are registered from the next-state values, so lights/walk/cur_ch
// always match the state register and never glitch.
module signal_ctrl #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned T_GREEN  = 4,
  parameter int unsigned T_YELLOW = 2,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned T_WALK   = 3,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic [N_CH-1:0]     req,
  input  logic                ped_req,
  input  logic                emerg,
  input  logic [CH_W-1:0]     emerg_ch,
  output logic [2*N_CH-1:0]   lights,
  output logic                walk,
  output logic [2:0]          state_o,
  output logic [CH_W-1:0]     cur_ch
);

  localparam int unsigned LW = 2 * N_CH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_ALLRED = 3'd3,
    S_WALK   = 3'd4,
    S_EMERG  = 3'd5
  } state_t;

  // Registered state
  state_t            r_state;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   r_last;
  logic [CNT_W-1:0]  r_timer;
  logic [N_CH-1:0]   r_pend;
  logic              r_ped;
  logic [LW-1:0]     r_lights;
  logic              r_walk;
  logic [2:0]        r_state_o;
  logic [CH_W-1:0]   r_cur_ch;

  // Combinational helpers
  logic [N_CH-1:0]   w_ch_oh;
  logic [N_CH-1:0]   w_req_ok;
  logic [N_CH-1:0]   w_pend_eff;
  logic [N_CH-1:0]   w_clr_mask;
  logic [N_CH-1:0]   w_pend_nxt;
  logic              w_ped_eff;
  logic              w_ped_nxt;
  logic              w_emerg_ok;
  logic              w_other_pend;
  logic              w_timer_done;
  logic              w_rr_found;
  logic [CH_W-1:0]   w_rr_ch;
  logic [CH_W-1:0]   w_rr_idx;
  state_t            w_dec_state;
  logic [CH_W-1:0]   w_dec_ch;
  state_t            w_nxt_state;
  logic [CH_W-1:0]   w_nxt_ch;
  logic [CNT_W-1:0]  w_nxt_timer;
  logic              w_enter_green;
  logic              w_enter_walk;
  logic              w_enter_emerg;

  function automatic logic [N_CH-1:0] ch_onehot(logic [CH_W-1:0] c);
    return N_CH'(1) << c;
  endfunction

  // Phase length minus one; the timer counts down to zero inside the phase
  function automatic logic [CNT_W-1:0] load_of(state_t s);
    logic [CNT_W-1:0] v;
    v = '0;
    case (s)
      S_GREEN:  v = CNT_W'(T_GREEN - 1);
      S_YELLOW: v = CNT_W'(T_YELLOW - 1);
      S_ALLRED: v = CNT_W'(T_ALLRED - 1);
      S_WALK:   v = CNT_W'(T_WALK - 1);
      default:  v = '0;
    endcase
    return v;
  endfunction

  // Two-bit light code placed at the slice of approach c; all others red
  function automatic logic [LW-1:0] lights_of(state_t s, logic [CH_W-1:0] c);
    logic [1:0] code;
    code = 2'b00;
    case (s)
      S_GREEN, S_EMERG: code = 2'b01;
      S_YELLOW:         code = 2'b10;
      default:          code = 2'b00;
    endcase
    return LW'(code) << {c, 1'b0};
  endfunction

  // cur_ch only names an approach that actually holds a non-red light
  function automatic logic [CH_W-1:0] cur_of(state_t s, logic [CH_W-1:0] c);
    return (s == S_GREEN || s == S_YELLOW || s == S_EMERG) ? c : '0;
  endfunction

  // An out-of-range emergency channel (non power-of-two N_CH) is ignored
  assign w_emerg_ok   = emerg & (32'(emerg_ch) < N_CH);
  assign w_timer_done = (r_timer == '0);
  assign w_ch_oh      = ch_onehot(r_ch);
  // The approach currently green cannot re-request itself
  assign w_req_ok     = (r_state == S_GREEN) ? (req & ~w_ch_oh) : req;
  assign w_pend_eff   = r_pend | w_req_ok;
  assign w_other_pend = |(w_pend_eff & ~w_ch_oh);
  assign w_ped_eff    = r_ped | (ped_req & (r_state != S_WALK));

  // Round-robin search for the first pending approach after last_served
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_ch    = '0;
    w_rr_idx   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_rr_idx = CH_W'((32'(r_last) + 32'(1) + i) % N_CH);
      if (!w_rr_found && w_pend_eff[w_rr_idx]) begin
        w_rr_found = 1'b1;
        w_rr_ch    = w_rr_idx;
      end
    end
  end

  // Decision point priority: emergency, pedestrian, then vehicle requests
  always_comb begin
    w_dec_state = S_IDLE;
    w_dec_ch    = r_ch;
    if (w_emerg_ok) begin
      w_dec_state = S_EMERG;
      w_dec_ch    = emerg_ch;
    end else if (w_ped_eff) begin
      w_dec_state = S_WALK;
    end else if (w_rr_found) begin
      w_dec_state = S_GREEN;
      w_dec_ch    = w_rr_ch;
    end
  end

  // Next-state and next-timer selection
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ch    = r_ch;
    unique case (r_state)
      S_IDLE: begin
        w_nxt_state = w_dec_state;
        w_nxt_ch    = w_dec_ch;
      end
      S_GREEN: begin
        if (w_emerg_ok && (emerg_ch == r_ch)) begin
          w_nxt_state = S_EMERG;
        end else if (w_emerg_ok) begin
          w_nxt_state = S_YELLOW;
        end else if (w_timer_done && (w_other_pend || w_ped_eff)) begin
          w_nxt_state = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (w_timer_done) w_nxt_state = S_ALLRED;
      end
      S_ALLRED: begin
        if (w_timer_done) begin
          w_nxt_state = w_dec_state;
          w_nxt_ch    = w_dec_ch;
        end
      end
      S_WALK: begin
        if (w_emerg_ok || w_timer_done) w_nxt_state = S_ALLRED;
      end
      S_EMERG: begin
        if (!emerg) w_nxt_state = S_YELLOW;
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_ch    = '0;
      end
    endcase

    if (w_nxt_state != r_state) begin
      w_nxt_timer = load_of(w_nxt_state);
    end else if (!w_timer_done) begin
      w_nxt_timer = r_timer - CNT_W'(1);
    end else begin
      w_nxt_timer = r_timer;
    end
  end

  // Entry strobes only fire on enabled cycles, since the state only moves then
  assign w_enter_green = ena & (w_nxt_state == S_GREEN) & (r_state != S_GREEN);
  assign w_enter_walk  = ena & (w_nxt_state == S_WALK)  & (r_state != S_WALK);
  assign w_enter_emerg = ena & (w_nxt_state == S_EMERG) & (r_state != S_EMERG);
  // A served-clear wins over a new request for the same approach
  assign w_clr_mask    = w_enter_green ? ch_onehot(w_nxt_ch) : '0;
  assign w_pend_nxt    = (r_pend | w_req_ok) & ~w_clr_mask;
  assign w_ped_nxt     = w_ped_eff & ~w_enter_walk;

  // State, timer, request latches and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_last    <= CH_W'(N_CH - 1);
      r_timer   <= '0;
      r_pend    <= '0;
      r_ped     <= 1'b0;
      r_lights  <= '0;
      r_walk    <= 1'b0;
      r_state_o <= 3'd0;
      r_cur_ch  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_ped  <= w_ped_nxt;
      if (ena) begin
        r_state   <= w_nxt_state;
        r_ch      <= w_nxt_ch;
        r_timer   <= w_nxt_timer;
        r_lights  <= lights_of(w_nxt_state, w_nxt_ch);
        r_walk    <= (w_nxt_state == S_WALK);
        r_state_o <= w_nxt_state;
        r_cur_ch  <= cur_of(w_nxt_state, w_nxt_ch);
        if (w_enter_green || w_enter_emerg) r_last <= w_nxt_ch;
      end
    end
  end

  assign lights  = r_lights;
  assign walk    = r_walk;
  assign state_o = r_state_o;
  assign cur_ch  = r_cur_ch;

endmodule

// File: tb/tb_signal_ctrl.sv
// tb_signal_ctrl: scenario bench for signal_ctrl at default parameters.
// Expected output words {state_o, lights, walk, cur_ch} are queued as each
// cycle's stimulus is driven and compared after the following clock edge.
module tb_signal_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       ped_req = 1'b0;
  logic       emerg = 1'b0;
  logic [1:0] emerg_ch = 2'd0;
  logic [7:0] lights;
  logic       walk;
  logic [2:0] state_o;
  logic [1:0] cur_ch;

  int n_checks = 0;
  int n_fail   = 0;

  logic [13:0] sb[$];
  logic [13:0] plan[$];

  signal_ctrl #(
    .N_CH(4), .CNT_W(8), .T_GREEN(4), .T_YELLOW(2), .T_ALLRED(1), .T_WALK(3)
  ) dut (
    .clk(clk), .reset(reset), .ena(ena), .req(req), .ped_req(ped_req),
    .emerg(emerg), .emerg_ch(emerg_ch), .lights(lights), .walk(walk),
    .state_o(state_o), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] ex(logic [2:0] st, logic [7:0] li, logic w, logic [1:0] ch);
    return {st, li, w, ch};
  endfunction

  task automatic plan_add(logic [13:0] word, int n);
    for (int i = 0; i < n; i++) plan.push_back(word);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req = 4'b0000; ped_req = 1'b0; emerg = 1'b0; emerg_ch = 2'd0; ena = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] got, want;
    #1 reset = 1'b1;
    #1;
    got  = {state_o, lights, walk, cur_ch};
    want = ex(3'd0, 8'h00, 1'b0, 2'd0);
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_async got=%h want=%h", got, want); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    plan.delete();
    plan_add(ex(3'd0, 8'h00, 1'b0, 2'd0), 10);
    for (int i = 0; i < plan.size(); i++) begin
      sb.push_back(plan[i]);
      @(posedge clk); #1;
      got  = {state_o, lights, walk, cur_ch};
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_single_req();
    logic [13:0] got, want;
    plan.delete();
    plan_add(ex(3'd1, 8'h10, 1'b0, 2'd2), 21);
    for (int i = 0; i < plan.size(); i++) begin
      req = (i == 0) ? 4'b0100 : 4'b0000;
      sb.push_back(plan[i]);
      @(posedge clk); #1;
      got  = {state_o, lights, walk, cur_ch};
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL single_req cyc=%0d got=%h want=%h", i, got, want); end
    end
    req = 4'b0000;
  endtask

  task automatic test_preempt_by_req();
    logic [13:0] got, want;
    plan.delete();
    plan_add(ex(3'd2, 8'h20, 1'b0, 2'd2), 2);
    plan_add(ex(3'd3, 8'h00, 1'b0, 2'd0), 1);
    plan_add(ex(3'd1, 8'h01, 1'b0, 2'd0), 1);
    for (int i = 0; i < plan.size(); i++) begin
      req = (i == 0) ? 4'b0001 : 4'b0000;
      sb.push_back(plan[i]);
      @(posedge clk); #1;
      got  = {state_o, lights, walk, cur_ch};
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL preempt_req cyc=%0d got=%h want=%h", i, got, want); end
    end
    req = 4'b0000;
  endtask

  task automatic test_walk();
    logic [13:0] got, want;
    plan.delete();
    plan_add(ex(3'd1, 8'h01, 1'b0, 2'd0), 3);
    plan_add(ex(3'd2, 8'h02, 1'b0, 2'd0), 2);
    plan_add(ex(3'd3, 8'h00, 1'b0, 2'd0), 1);
    plan_add(ex(3'd4, 8'h00, 1'b1, 2'd0), 3);
    plan_add(ex(3'd3, 8'h00, 1'b0, 2'd0), 1);
    plan_add(ex(3'd0, 8'h00, 1'b0, 2'd0), 1);
    for (int i = 0; i < plan.size(); i++) begin
      ped_req = (i == 1 || i == 7);
      sb.push_back(plan[i]);
      @(posedge clk); #1;
      got  = {state_o, lights, walk, cur_ch};
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL walk cyc=%0d got=%h want=%h", i, got, want); end
    end
    ped_req = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [13:0] got, want;
    plan.delete();
    plan_add(ex(3'd1, 8'h04, 1'b0, 2'd1), 5);
    plan_add(ex(3'd2, 8'h08, 1'b0, 2'd1), 2);
    plan_add(ex(3'd3, 8'h00, 1'b0, 2'd0), 1);
    plan_add(ex(3'd1, 8'h40, 1'b0, 2'd3), 4);
    plan_add(ex(3'd2, 8'h80, 1'b0, 2'd3), 2);
    plan_add(ex(3'd3, 8'h00, 1'b0, 2'd0), 1);
    plan_add(ex(3'd1, 8'h01, 1'b0, 2'd0), 4);
    plan_add(ex(3'd2, 8'h02, 1'b0, 2'd0), 2);
    plan_add(ex(3'd3, 8'h00, 1'b0, 2'd0), 1);
    plan_add(ex(3'd1, 8'h04, 1'b0, 2'd1), 6);
    for (int i = 0; i < plan.size(); i++) begin
      req = (i == 0) ? 4'b0010 : (i == 5) ? 4'b1001 : (i == 6) ? 4'b0010 : 4'b0000;
      sb.push_back(plan[i]);
      @(posedge clk); #1;
      got  = {state_o, lights, walk, cur_ch};
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL round_robin cyc=%0d got=%h want=%h", i, got, want); end
    end
    req = 4'b0000;
  endtask

  task automatic test_ena_hold();
    logic [13:0] got, want;
    apply_reset();
    plan.delete();
    plan_add(ex(3'd0, 8'h00, 1'b0, 2'd0), 3);
    plan_add(ex(3'd1, 8'h01, 1'b0, 2'd0), 7);
    for (int i = 0; i < plan.size(); i++) begin
      ena = (i >= 3);
      req = (i == 0 || i == 7) ? 4'b0001 : 4'b0000;
      sb.push_back(plan[i]);
      @(posedge clk); #1;
      got  = {state_o, lights, walk, cur_ch};
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL ena_hold cyc=%0d got=%h want=%h", i, got, want); end
    end
    req = 4'b0000; ena = 1'b1;
  endtask

  task automatic test_emerg_same();
    logic [13:0] got, want;
    plan.delete();
    plan_add(ex(3'd5, 8'h01, 1'b0, 2'd0), 2);
    plan_add(ex(3'd2, 8'h02, 1'b0, 2'd0), 2);
    plan_add(ex(3'd3, 8'h00, 1'b0, 2'd0), 1);
    plan_add(ex(3'd0, 8'h00, 1'b0, 2'd0), 1);
    for (int i = 0; i < plan.size(); i++) begin
      emerg    = (i < 2);
      emerg_ch = (i == 1) ? 2'd2 : 2'd0;
      sb.push_back(plan[i]);
      @(posedge clk); #1;
      got  = {state_o, lights, walk, cur_ch};
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL emerg_same cyc=%0d got=%h want=%h", i, got, want); end
    end
    emerg = 1'b0; emerg_ch = 2'd0;
  endtask

  task automatic test_emerg_other();
    logic [13:0] got, want;
    apply_reset();
    plan.delete();
    plan_add(ex(3'd1, 8'h04, 1'b0, 2'd1), 2);
    plan_add(ex(3'd2, 8'h08, 1'b0, 2'd1), 2);
    plan_add(ex(3'd3, 8'h00, 1'b0, 2'd0), 1);
    plan_add(ex(3'd5, 8'h40, 1'b0, 2'd3), 3);
    plan_add(ex(3'd2, 8'h80, 1'b0, 2'd3), 2);
    for (int i = 0; i < plan.size(); i++) begin
      req      = (i == 0) ? 4'b0010 : 4'b0000;
      emerg    = (i >= 2 && i < 8);
      emerg_ch = (i >= 6) ? 2'd0 : 2'd3;
      sb.push_back(plan[i]);
      @(posedge clk); #1;
      got  = {state_o, lights, walk, cur_ch};
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL emerg_other cyc=%0d got=%h want=%h", i, got, want); end
    end
    reset = 1'b1;
    #1;
    got  = {state_o, lights, walk, cur_ch};
    want = ex(3'd0, 8'h00, 1'b0, 2'd0);
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_mid_yellow got=%h want=%h", got, want); end
    @(posedge clk); #1;
    reset = 1'b0;
    req = 4'b0000; emerg = 1'b0; emerg_ch = 2'd0;
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_preempt_by_req();
    test_walk();
    test_round_robin();
    test_ena_hold();
    test_emerg_same();
    test_emerg_other();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signal_ctrl.md
SIGNAL_CTRL -- requirements
Module: signal_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N_CH, 4: number of vehicle approaches, legal 2..8.
- CNT_W, 8: phase timer width.
- T_GREEN, 4: minimum green cycles.
- T_YELLOW, 2: yellow cycles.
- T_ALLRED, 1: all-red clearance cycles.
- T_WALK, 3: pedestrian walk cycles.
- Every T_* value is in 1..2^CNT_W-1; CH_W = max(1, clog2(N_CH)).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high.
- ena, in, 1: when low, state, timer, pointer and latches hold; request latching continues.
- req, in, N_CH: per-approach vehicle request, sampled each cycle.
- ped_req, in, 1: pedestrian request.
- emerg, in, 1: emergency preemption, level.
- emerg_ch, in, CH_W: approach given to the emergency vehicle.
- lights, out, 2*N_CH: 2-bit code per approach in slice [2k+1:2k]; 00 RED, 01 GREEN, 10 YELLOW, 11 never driven.
- walk, out, 1: pedestrian walk indication.
- state_o, out, 3: encoded state; IDLE=0, GREEN=1, YELLOW=2, ALLRED=3, WALK=4, EMERG=5.
- cur_ch, out, CH_W: approach currently green, yellow or emergency.

Function
REQ-003 All outputs are registered; lights, walk and cur_ch are a pure function of the registered state.
REQ-004 pend[k] is set when req[k]=1; it is cleared on the cycle approach k enters GREEN. req[k] is ignored while k is green.
REQ-005 ped_pend is set by ped_req; it is cleared on WALK entry; ped_req is ignored while in WALK.
REQ-006 At a decision point (IDLE each cycle, or ALLRED expiry) the priority is emerg, then ped_pend, then any pend.
- emerg -> EMERG on emerg_ch.
- ped_pend -> WALK.
- pend -> GREEN on the first pending approach searched from (last_served+1) mod N_CH.
- Nothing pending -> IDLE.
REQ-007 The phase timer loads T_x-1 on state entry and decrements each enabled cycle to 0, so each phase lasts exactly T_x cycles.
REQ-008 GREEN(c): lights[c]=01, all others 00. When the timer reaches 0 and some other pend[j], j!=c, or ped_pend is set, the next state is YELLOW. Otherwise GREEN rests indefinitely.
REQ-009 YELLOW(c): lights[c]=10, others 00; lasts T_YELLOW cycles, then ALLRED.
REQ-010 ALLRED and IDLE: all lights 00; ALLRED lasts T_ALLRED cycles, then makes a decision per REQ-006.
REQ-011 WALK: all lights 00, walk=1 for T_WALK cycles, then ALLRED.
REQ-012 Emergency preemption, evaluated every enabled cycle:
- GREEN(c) with emerg_ch==c -> EMERG(c) immediately, timer ignored.
- GREEN(c) with emerg_ch!=c -> YELLOW(c) on the next cycle, truncating green.
- WALK -> ALLRED on the next cycle, walk drops.
- YELLOW and ALLRED run to completion.
REQ-013 EMERG(c): lights[c]=01, c is latched on entry and further emerg_ch changes are ignored. When emerg=0 -> YELLOW(c). last_served becomes c.
REQ-014 last_served updates on every GREEN entry; with a single pending approach equal to last_served, that approach is still selected.
REQ-015 No approach is ever GREEN or YELLOW simultaneously with another approach or with walk=1.
REQ-016 The timer saturates at 0 and never wraps.
REQ-017 A req and a served-clear on the same cycle for the same approach resolve to clear.

Reset
REQ-018 With reset=1 the outputs are immediately: state IDLE, lights all 00, walk 0, cur_ch 0. In addition: timer 0, pend 0, ped_pend 0, last_served N_CH-1 (so the first search starts at 0).
REQ-019 Reset asserted mid-phase aborts that phase asynchronously; all latched requests are lost.

Verification
REQ-020 The bench uses defaults (N_CH=4, T_GREEN=4, T_YELLOW=2, T_ALLRED=1, T_WALK=3) and covers these scenarios:
- Reset, then idle 10 cycles -> lights=8'h00, walk=0, state_o=0 throughout.
- req=4'b0100 pulsed one cycle -> next edge lights=8'h10, cur_ch=2. With no further requests it rests green for 20 cycles.
- While ch2 rests green, pulse req[0] -> 1 cycle later lights=8'h20 for 2 cycles, 8'h00 for 1 cycle, then 8'h01, cur_ch=0.
- pend=4'b1011 with last_served=1 -> service order 3, 0, 1. Each green is 4 cycles, separated by 2 yellow + 1 all-red cycles.
- ped_req during ch0 green at timer=2 -> green completes 4 cycles, yellow 2, all-red 1, then walk=1 for exactly 3 cycles with lights=8'h00.
- emerg=1 with emerg_ch=3 during ch1 green at cycle 1 -> next cycle lights=8'h08, then 8'h00, then 8'h40 held while emerg=1. On emerg=0 -> 8'h80 for 2 cycles. Reset asserted during that yellow -> lights=8'h00 the same cycle, with no clock edge.
